// File: rtl/activation_pipe.sv
// activation_pipe: two-stage streaming activation over LANES IEEE-754 singles.
// Stage 1 captures the beat and its mode, stage 2 holds the activated result
// and drives the output port. Handshake contract (both sides): a beat moves
// across an interface on a rising edge where valid and ready are both high;
// valid never depends on ready, and a presented output beat holds its data
// stable until it is taken.
module activation_pipe #(
  parameter int          LANES      = 4,
  parameter int          LEAK_SHIFT = 3,
  parameter logic [31:0] CLAMP_BITS = 32'h40C00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [32*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_zero_mask,
  output logic [31:0]           beat_count
);

  localparam int          W  = 32 * LANES;
  localparam logic [7:0]  LS = 8'(LEAK_SHIFT);
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] NEG_ZERO = 32'h80000000;

  logic             s1_valid_q;
  logic [1:0]       s1_mode_q;
  logic [W-1:0]     s1_data_q;
  logic             s2_valid_q;
  logic [W-1:0]     s2_data_q;
  logic [LANES-1:0] s2_zmask_q;
  logic [31:0]      beat_cnt_q;

  logic             s1_adv;
  logic             s2_adv;
  logic [W-1:0]     res_d;
  logic [LANES-1:0] zmask_d;

  // Activation of a single lane. Positive floats order like unsigned
  // integers, so the clamp is a plain unsigned compare.
  function automatic logic [31:0] act_lane(input logic [31:0] x, input logic [1:0] mode);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [31:0] r;
    s = x[31];
    e = x[30:23];
    m = x[22:0];
    r = x;
    if (mode != 2'd0 && e == 8'hFF && m != 23'd0) begin
      r = QNAN;
    end else begin
      case (mode)
        2'd1: r = s ? 32'd0 : x;
        2'd2: begin
          if (s) begin
            if (e == 8'hFF)   r = x;                       // -inf stays -inf
            else if (e > LS)  r = {1'b1, e - LS, m};       // exact scale by 2^-LEAK_SHIFT
            else              r = NEG_ZERO;                // would go denormal: flush
          end
        end
        2'd3: begin
          r = s ? 32'd0 : x;
          if (r > CLAMP_BITS) r = CLAMP_BITS;
        end
        default: r = x;
      endcase
    end
    return r;
  endfunction

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Per-lane activation of the stage-1 beat and its zero flags.
  always_comb begin
    res_d   = '0;
    zmask_d = '0;
    for (int i = 0; i < LANES; i++) begin
      res_d[32*i +: 32] = act_lane(s1_data_q[32*i +: 32], s1_mode_q);
      zmask_d[i]        = (res_d[32*i +: 31] == 31'd0);
    end
  end

  // Stage 1: capture an accepted input beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 2'd0;
      s1_data_q  <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= in_mode;
        s1_data_q <= in_data;
      end
    end
  end

  // Stage 2: capture the activated result; holds while stalled downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_zmask_q <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q  <= res_d;
        s2_zmask_q <= zmask_d;
      end
    end
  end

  // Count completed output handshakes; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= 32'd0;
    end else if (s2_valid_q && out_ready) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_data      = s2_data_q;
  assign out_zero_mask = s2_zmask_q;
  assign beat_count    = beat_cnt_q;

endmodule

// File: tb/tb_activation_pipe.sv
// Bench for activation_pipe: directed beats with hand-computed results,
// scoreboard queue filled by the driver and drained by an output monitor.
module tb_activation_pipe;

  localparam int LANES = 4;
  localparam int W     = 32 * LANES;
  localparam int EW    = W + LANES;
  localparam int NV    = 11;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [LANES-1:0] out_zero_mask;
  logic [31:0]      beat_count;

  logic [EW-1:0] exp_q[$];
  int            n_vec;
  int            n_miss;
  int            n_pops;
  int            or_mode;     // 0: ready high, 1: ready low, 2: random

  logic [1:0]       tv_mode [NV];
  logic [W-1:0]     tv_in   [NV];
  logic [W-1:0]     tv_out  [NV];
  logic [LANES-1:0] tv_mask [NV];

  activation_pipe #(.LANES(LANES), .LEAK_SHIFT(3), .CLAMP_BITS(32'h40C00000)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mode       (in_mode),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_zero_mask (out_zero_mask),
    .beat_count    (beat_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Downstream ready driver, updated 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    if (or_mode == 0)      out_ready = 1'b1;
    else if (or_mode == 1) out_ready = 1'b0;
    else                   out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops and compares on every output handshake, checks hold while stalled
  logic          stall_q;
  logic [EW-1:0] held_q;
  initial begin
    stall_q = 1'b0;
    held_q  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk("stall_valid_hold", EW'(out_valid), EW'(1'b1));
          chk("stall_data_hold", {out_zero_mask, out_data}, held_q);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {out_zero_mask, out_data}, '0);
            if ({out_zero_mask, out_data} == '0) begin
              n_miss++;
              $display("FAIL unexpected_beat: got beat with empty queue, expected none");
            end
          end else begin
            chk("out_beat", {out_zero_mask, out_data}, exp_q.pop_front());
          end
          n_pops++;
          stall_q = 1'b0;
        end else if (out_valid) begin
          stall_q = 1'b1;
          held_q  = {out_zero_mask, out_data};
        end else begin
          stall_q = 1'b0;
        end
      end
    end
  end

  // Driver: present one beat, wait for the handshake, record the expected result
  task automatic send(input logic [1:0] mode, input logic [W-1:0] d,
                      input logic [W-1:0] ed, input logic [LANES-1:0] em);
    int   budget;
    logic acc;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = d;
    budget   = 0;
    acc      = 1'b0;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      budget++;
    end
    if (acc) begin
      exp_q.push_back({em, ed});
    end else begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    #1;
  endtask

  task automatic send_tv(input int k);
    send(tv_mode[k], tv_in[k], tv_out[k], tv_mask[k]);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = 2'd0;
  endtask

  task automatic set_ready(input int m);
    or_mode = m;
    @(posedge clk);
    #3;
  endtask

  task automatic wait_drain();
    int budget;
    set_ready(0);
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #3;
  endtask

  initial begin
    int bp_base;
    n_vec = 0; n_miss = 0; n_pops = 0; or_mode = 0;
    out_ready = 1'b1;
    rst = 1'b1;
    idle();

    tv_mode[0] = 2'd1; tv_in[0] = {32'h40000000, 32'hC0000000, 32'h3F800000, 32'hBF800000};
    tv_out[0] = {32'h40000000, 32'h00000000, 32'h3F800000, 32'h00000000}; tv_mask[0] = 4'b0101;
    tv_mode[1] = 2'd2; tv_in[1] = {32'h80400000, 32'h3F800000, 32'hBF800000, 32'hC1000000};
    tv_out[1] = {32'h80000000, 32'h3F800000, 32'hBE000000, 32'hBF800000}; tv_mask[1] = 4'b1000;
    tv_mode[2] = 2'd3; tv_in[2] = {32'h7FC00001, 32'h7F800000, 32'h40A00000, 32'h40E00000};
    tv_out[2] = {32'h7FC00000, 32'h40C00000, 32'h40A00000, 32'h40C00000}; tv_mask[2] = 4'b0000;
    tv_mode[3] = 2'd0; tv_in[3] = {32'h7FC00001, 32'h7F800000, 32'h40A00000, 32'h40E00000};
    tv_out[3] = {32'h7FC00001, 32'h7F800000, 32'h40A00000, 32'h40E00000}; tv_mask[3] = 4'b0000;
    tv_mode[4] = 2'd2; tv_in[4] = {32'h00000000, 32'hFF800000, 32'h82000000, 32'h81800000};
    tv_out[4] = {32'h00000000, 32'hFF800000, 32'h80800000, 32'h80000000}; tv_mask[4] = 4'b1001;
    tv_mode[5] = 2'd3; tv_in[5] = {32'h7F800000, 32'h80000000, 32'h40C00001, 32'h40C00000};
    tv_out[5] = {32'h40C00000, 32'h00000000, 32'h40C00000, 32'h40C00000}; tv_mask[5] = 4'b0100;
    tv_mode[6] = 2'd1; tv_in[6] = {32'hFFC00001, 32'h80000000, 32'h00000001, 32'h7F800000};
    tv_out[6] = {32'h7FC00000, 32'h00000000, 32'h00000001, 32'h7F800000}; tv_mask[6] = 4'b0100;
    // Same data, modes 1,2,3,0 back to back
    for (int k = 7; k < 11; k++) tv_in[k] = {32'hC1000000, 32'h7FC00001, 32'h40E00000, 32'hBF800000};
    tv_mode[7]  = 2'd1; tv_out[7]  = {32'h00000000, 32'h7FC00000, 32'h40E00000, 32'h00000000}; tv_mask[7]  = 4'b1001;
    tv_mode[8]  = 2'd2; tv_out[8]  = {32'hBF800000, 32'h7FC00000, 32'h40E00000, 32'hBE000000}; tv_mask[8]  = 4'b0000;
    tv_mode[9]  = 2'd3; tv_out[9]  = {32'h00000000, 32'h7FC00000, 32'h40C00000, 32'h00000000}; tv_mask[9]  = 4'b1001;
    tv_mode[10] = 2'd0; tv_out[10] = {32'hC1000000, 32'h7FC00001, 32'h40E00000, 32'hBF800000}; tv_mask[10] = 4'b0000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", EW'(out_valid), EW'(1'b0));
    chk("reset_out_data", {out_zero_mask, out_data}, '0);
    chk("reset_beat_count", EW'(beat_count), EW'(0));
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", EW'(in_ready), EW'(1'b1));

    // Single beat, latency 2
    send_tv(0);
    idle();
    chk("latency_e1_valid", EW'(out_valid), EW'(1'b0));
    @(posedge clk); #1;
    chk("latency_e2_valid", EW'(out_valid), EW'(1'b1));
    wait_drain();

    // Back-to-back directed vectors, then mode switching on identical data
    for (int k = 1; k < NV; k++) send_tv(k);
    idle();
    wait_drain();
    chk("beat_count_run", EW'(beat_count), EW'(n_pops));

    // in_ready drops once two beats are held
    set_ready(1);
    send_tv(0);
    send_tv(1);
    idle();
    @(negedge clk);
    chk("in_ready_full", EW'(in_ready), EW'(1'b0));
    repeat (3) @(posedge clk);
    wait_drain();

    // Random backpressure stream of 10 beats
    bp_base = n_pops;
    set_ready(2);
    for (int k = 0; k < 10; k++) send_tv(k % 7);
    idle();
    wait_drain();
    chk("stream_beat_count", EW'(beat_count), EW'(bp_base + 10));

    // Asynchronous reset with two beats in flight
    set_ready(1);
    send_tv(2);
    send_tv(5);
    idle();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", EW'(out_valid), EW'(1'b0));
    chk("midreset_beat_count", EW'(beat_count), EW'(0));
    exp_q.delete();
    n_pops = 0;
    @(posedge clk); #2;
    rst = 1'b0;
    set_ready(0);
    chk("postreset_out_valid", EW'(out_valid), EW'(1'b0));
    send_tv(4);
    idle();
    chk("postreset_e1_valid", EW'(out_valid), EW'(1'b0));
    @(posedge clk); #1;
    chk("postreset_e2_valid", EW'(out_valid), EW'(1'b1));
    wait_drain();
    chk("postreset_beat_count", EW'(beat_count), EW'(1));
    chk("queue_empty", EW'(exp_q.size()), EW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
